// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// state encoding, IR field positions, opcodes and the ALU opcode table.
package cpu_ctrl_pkg;

    // 4-bit state encoding, exported unchanged on state_out
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7,
        ST_ILL  = 4'd8,
        ST_ERR  = 4'd9
    } state_t;

    // IR field bit positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    // Opcodes of the ISA that matter to this unit
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;

    // One bit per DataPath control strobe
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlo_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic y_in;
        logic alu_in;
    } strobes_t;

    // Opcode -> {valid, alu code}. Only single-cycle 3-register ALU ops are
    // valid; mul/div need the HI/LO path and are treated as unsupported.
    function automatic logic [5:0] op_to_alu(input logic [4:0] op);
        logic [5:0] res;
        case (op)
            OP_ADD:  res = {1'b1, 5'b00001};
            OP_SUB:  res = {1'b1, 5'b00010};
            OP_AND:  res = {1'b1, 5'b01111};
            OP_OR:   res = {1'b1, 5'b01110};
            OP_ROR:  res = {1'b1, 5'b00111};
            OP_ROL:  res = {1'b1, 5'b01000};
            OP_SHR:  res = {1'b1, 5'b01001};
            OP_SHRA: res = {1'b1, 5'b01010};
            OP_SHL:  res = {1'b1, 5'b01011};
            default: res = 6'b000000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational strobe decoder: maps the registered state (plus the latched
// IR opcode and first-T1-cycle flag) onto the DataPath control strobes.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  state_t     state,
    input  logic       first_t1,
    input  logic [4:0] op,
    output strobes_t   strobes,
    output logic [4:0] alucontrol,
    output logic       alu_valid
);

    logic [5:0] entry;

    assign entry     = op_to_alu(op);
    assign alu_valid = entry[5];

    // Moore strobe decode; only one bus driver is ever asserted per state
    always_comb begin
        strobes    = '0;
        alucontrol = '0;
        case (state)
            ST_T0: begin
                strobes.pc_out = 1'b1;
                strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1;
                strobes.alu_in = 1'b1;
            end
            ST_T1: begin
                strobes.zlo_out = 1'b1;
                strobes.pc_in   = first_t1;
                strobes.read    = 1'b1;
                strobes.mdr_in  = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            ST_T3: begin
                // HALT and unsupported opcodes leave T3 without touching Y
                if (entry[5] && (op != HALT_OP)) begin
                    strobes.grb   = 1'b1;
                    strobes.r_out = 1'b1;
                    strobes.y_in  = 1'b1;
                end
            end
            ST_T4: begin
                strobes.grc    = 1'b1;
                strobes.r_out  = 1'b1;
                strobes.alu_in = 1'b1;
                alucontrol     = entry[4:0];
            end
            ST_T5: begin
                strobes.zlo_out = 1'b1;
                strobes.gra     = 1'b1;
                strobes.r_in    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the DataPath: steps fetch T0..T2 and a
// 3-register ALU execute T3..T5, waits for memory in T1 with a timeout and
// traps HALT and unsupported opcodes in sticky terminal states.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         WAIT_LIMIT = 16,
    parameter logic [4:0] HALT_OP    = 5'b11011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        ZLOout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Yin,
    output logic        ALUIn,
    output logic [4:0]  alucontrol,
    output logic [3:0]  state_out,
    output logic        busy,
    output logic        illegal,
    output logic        err_timeout
);

    localparam int             CW        = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(WAIT_LIMIT - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    op;
    logic          alu_valid;
    strobes_t      strobes;
    logic          unused_ir;

    assign op        = ir[OP_HI:OP_LO];
    // Register fields are consumed by the DataPath decoder, not here
    assign unused_ir = ^ir[RA_HI:0];

    ctrl_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .state      (state),
        .first_t1   (wait_cnt == '0),
        .op         (op),
        .strobes    (strobes),
        .alucontrol (alucontrol),
        .alu_valid  (alu_valid)
    );

    // Sequencer FSM with memory-wait counter and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (run) state <= ST_T0;
                ST_T0: begin
                    wait_cnt <= '0;
                    state    <= ST_T1;
                end
                ST_T1: begin
                    // A ready memory wins even on the cycle the limit is reached
                    if (mem_rdy) begin
                        state <= ST_T2;
                    end else begin
                        if (wait_cnt != CNT_LIMIT) wait_cnt <= wait_cnt + CNT_ONE;
                        if (wait_cnt >= LAST_WAIT) begin
                            state       <= ST_ERR;
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_T2: state <= ST_T3;
                ST_T3: begin
                    if (op == HALT_OP) begin
                        state <= ST_HALT;
                    end else if (!alu_valid) begin
                        state   <= ST_ILL;
                        illegal <= 1'b1;
                    end else begin
                        state <= ST_T4;
                    end
                end
                ST_T4: state <= ST_T5;
                ST_T5: state <= run ? ST_T0 : ST_IDLE;
                ST_HALT, ST_ILL, ST_ERR: state <= state;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign PCout     = strobes.pc_out;
    assign MARin     = strobes.mar_in;
    assign IncPC     = strobes.inc_pc;
    assign ZLOout    = strobes.zlo_out;
    assign PCin      = strobes.pc_in;
    assign Read      = strobes.read;
    assign MDRin     = strobes.mdr_in;
    assign MDRout    = strobes.mdr_out;
    assign IRin      = strobes.ir_in;
    assign Gra       = strobes.gra;
    assign Grb       = strobes.grb;
    assign Grc       = strobes.grc;
    assign Rin       = strobes.r_in;
    assign Rout      = strobes.r_out;
    assign Yin       = strobes.y_in;
    assign ALUIn     = strobes.alu_in;
    assign state_out = state;
    assign busy      = !((state == ST_IDLE) || (state == ST_HALT) || (state == ST_ERR));

endmodule
